// File: rtl/pc_pkg.sv
// Shared types and default addresses for the fetch-side PC controller.
package pc_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLEZ = 3'd3,
      BR_BGTZ = 3'd4,
      BR_BLTZ = 3'd5,
      BR_BGEZ = 3'd6
   } br_type_e;

   typedef enum logic [1:0] {
      J_NONE = 2'd0,
      J_J    = 2'd1,
      J_JAL  = 2'd2,
      J_JR   = 2'd3
   } j_type_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DEFAULT_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/pc_ctrl_if.sv
// Fetch/ID redirect bundle between the pipeline (master) and the PC controller (slave).
interface pc_ctrl_if import pc_pkg::*; #(
   parameter int XLEN = 32
);

   logic            stall_if;
   logic            flush_exc;
   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   br_type_e        br_type;
   j_type_e         j_type;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;
   logic [25:0]     imm26;
   logic [XLEN-1:0] pc;
   logic            taken;
   logic            flush_if;
   logic [XLEN-1:0] link_addr;

   modport master (
      output stall_if, flush_exc, id_valid, id_pc, br_type, j_type,
             rs_val, rt_val, imm26,
      input  pc, taken, flush_if, link_addr
   );

   modport slave (
      input  stall_if, flush_exc, id_valid, id_pc, br_type, j_type,
             rs_val, rt_val, imm26,
      output pc, taken, flush_if, link_addr
   );

endinterface

// File: rtl/pc_ctrl_br_cmp.sv
// Combinational signed branch-condition evaluator for the ID stage.
module br_cmp import pc_pkg::*; #(
   parameter int XLEN = 32
) (
   input  br_type_e        br_type,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   output logic            cond
);

   localparam logic signed [XLEN-1:0] ZERO = '0;

   logic signed [XLEN-1:0] rs_s;

   assign rs_s = $signed(rs_val);

   always_comb begin
      cond = 1'b0;
      case (br_type)
         BR_BEQ:  cond = (rs_val == rt_val);
         BR_BNE:  cond = (rs_val != rt_val);
         BR_BLEZ: cond = (rs_s <= ZERO);
         BR_BGTZ: cond = (rs_s >  ZERO);
         BR_BLTZ: cond = (rs_s <  ZERO);
         BR_BGEZ: cond = (rs_s >= ZERO);
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch PC register with branch/jump/exception redirect and a pending-redirect latch for stalls.
// Optional macro DELAY_SLOT_EN selects MIPS delay-slot link address and IF flush behaviour.
module pc_ctrl import pc_pkg::*; #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
   parameter logic [XLEN-1:0] EXC_VEC  = XLEN'(DEFAULT_EXC_VEC)
) (
   input logic       clk,
   input logic       rst_n,
   pc_ctrl_if.slave  bus
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pend_pc;
   logic            pend_valid;
   logic [XLEN-1:0] pc4;
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] br_target;
   logic [XLEN-1:0] j_target;
   logic [XLEN-1:0] target;
   logic            cond;
   logic            redirect;

   br_cmp #(.XLEN(XLEN)) u_br_cmp (
      .br_type (bus.br_type),
      .rs_val  (bus.rs_val),
      .rt_val  (bus.rt_val),
      .cond    (cond)
   );

   assign pc4       = bus.id_pc + XLEN'(4);
   assign imm_ext   = {{(XLEN-16){bus.imm26[15]}}, bus.imm26[15:0]};
   assign br_target = pc4 + (imm_ext << 2);
   assign j_target  = {pc4[XLEN-1:28], bus.imm26, 2'b00};

   // Jumps outrank the branch field when both are encoded.
   always_comb begin
      target = br_target;
      case (bus.j_type)
         J_J, J_JAL: target = j_target;
         J_JR:       target = bus.rs_val;
         default:    target = br_target;
      endcase
   end

   assign redirect = rst_n & bus.id_valid & ((bus.j_type != J_NONE) | cond);

   assign bus.taken = redirect;
   assign bus.pc    = pc_q;

`ifdef DELAY_SLOT_EN
   assign bus.link_addr = bus.id_pc + XLEN'(8);
   assign bus.flush_if  = rst_n & bus.flush_exc;
`else
   assign bus.link_addr = bus.id_pc + XLEN'(4);
   assign bus.flush_if  = rst_n & (bus.flush_exc | redirect);
`endif

   // A redirect seen during a stall is parked and replayed on the first free cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         pend_valid <= 1'b0;
         pend_pc    <= '0;
      end else if (bus.flush_exc) begin
         pc_q       <= EXC_VEC;
         pend_valid <= 1'b0;
      end else if (redirect) begin
         if (bus.stall_if) begin
            pend_valid <= 1'b1;
            pend_pc    <= target;
         end else begin
            pc_q       <= target;
            pend_valid <= 1'b0;
         end
      end else if (pend_valid && !bus.stall_if) begin
         pc_q       <= pend_pc;
         pend_valid <= 1'b0;
      end else if (!bus.stall_if) begin
         pc_q <= pc_q + XLEN'(4);
      end
   end

endmodule
